// File: rtl/imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe
//
// Pipelined immediate-extension unit between decode and the ALU operand mux.
// Extends an IN_W-bit raw immediate to OUT_W bits in one of four modes and
// presents it one cycle later on a valid/ready interface. A 2-entry skid
// buffer lets in_ready be a pure flop with no combinational path from
// out_ready.
//
// Parameters:
//   IN_W   width of the raw immediate field (default 16)
//   OUT_W  width of the extended result (default 32), must be >= IN_W
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   immediate/mode presented
//   in_ready   unit can accept (registered)
//   in_imm     raw immediate [IN_W-1:0]
//   in_mode    00 sign, 01 zero, 10 branch (sign then <<2), 11 upper
//   out_valid  result valid
//   out_ready  consumer accepts
//   out_data   extended result [OUT_W-1:0]
//   out_mode   mode captured with the result
//   xfer_cnt   saturating count of output transfers; present only when
//              IMMX_XFER_CNT_EN is defined
// ---------------------------------------------------------------------------
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_mode
`ifdef IMMX_XFER_CNT_EN
    ,
    output logic [15:0]      xfer_cnt
`endif
);

    generate
        if (OUT_W < IN_W) begin : g_bad_widths
            $error("imm_extend_pipe: OUT_W must be >= IN_W");
        end
    endgenerate

    localparam logic [1:0] EMPTY = 2'd0;  // nothing held
    localparam logic [1:0] ONE   = 2'd1;  // output register holds a value
    localparam logic [1:0] FULL  = 2'd2;  // output and skid both hold values

    localparam logic [1:0] MODE_SIGN   = 2'b00;
    localparam logic [1:0] MODE_ZERO   = 2'b01;
    localparam logic [1:0] MODE_BRANCH = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [OUT_W-1:0] skid_data;
    logic [1:0]       skid_mode;
    logic [OUT_W-1:0] ext;
    logic             in_fire, out_fire;
    logic             load_out_new, load_out_skid, load_skid;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_valid = (state_q != EMPTY);

    // ---------------------------------------------------------------------
    // Extension. A signed view of the immediate lets a width cast do the
    // sign replication, which also stays legal when OUT_W == IN_W.
    // ---------------------------------------------------------------------
    logic signed [IN_W-1:0] imm_s;
    assign imm_s = in_imm;

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        ext = OUT_W'(in_imm);
        case (in_mode)
            MODE_SIGN:   ext = OUT_W'(imm_s);
            MODE_ZERO:   ext = OUT_W'(in_imm);
            MODE_BRANCH: ext = OUT_W'(imm_s) << 2;  // top two bits fall off
            default:     ext = OUT_W'(in_imm) << (OUT_W - IN_W);
        endcase
    end

    // ---------------------------------------------------------------------
    // Control: decides the next state and which register loads what.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d      = ONE;
                    load_out_new = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && !out_fire) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (in_fire && out_fire) begin
                    load_out_new = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (out_fire) begin
                    state_d       = ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state_q  <= state_d;
            // Registered ready: low only while the skid entry is occupied.
            in_ready <= (state_d != FULL);
        end
    end

    // NOTE: the data registers are reset too, because out_data must read
    // zero during reset and no stale skid entry may survive it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_mode  <= '0;
            skid_data <= '0;
            skid_mode <= '0;
        end else begin
            if (load_out_new) begin
                out_data <= ext;
                out_mode <= in_mode;
            end else if (load_out_skid) begin
                out_data <= skid_data;
                out_mode <= skid_mode;
            end
            if (load_skid) begin
                skid_data <= ext;
                skid_mode <= in_mode;
            end
        end
    end

`ifdef IMMX_XFER_CNT_EN
    // Saturating count of values handed to the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (out_fire && (xfer_cnt != 16'hFFFF)) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end
`else
    // Transfer counter not built in this configuration.
`endif

endmodule
